// File: rtl/z3_pkg.sv
// Shared types and constants for the Zorro III slave-cycle controller.
package z3_pkg;

  localparam int Z3_ADDR_W  = 32;
  localparam int Z3_AHI_LSB = 24;
  localparam int Z3_AHI_W   = Z3_ADDR_W - Z3_AHI_LSB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT_DS,
    ST_WAIT_ACK,
    ST_HOLD,
    ST_BURST,
    ST_MISS
  } z3_state_e;

  // Region index width, never narrower than one bit.
  function automatic int region_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/z3_sync.sv
// Two-flop synchroniser bank for asynchronous active-low bus strobes; idles high.
module z3_sync
  import z3_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/z3_slave_ctrl.sv
// Zorro III slave-cycle controller: region decode, SLAVE_n/DTACK_n/MTACK_n generation
// and a req/ack handshake towards the memory backend, with optional burst support.
module z3_slave_ctrl
  import z3_pkg::*;
#(
  parameter int N_REGIONS    = 2,
  parameter int MULTI_XFER   = 1,
  parameter int TIMEOUT_CLKS = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fcs_n,
  input  logic [3:0]                      ds_n,
  input  logic                            mtcr_n,
  input  logic                            read,
  input  logic                            doe,
  input  logic                            berr_n,
  input  logic [Z3_AHI_W-1:0]             addr_hi,
  input  logic [Z3_AHI_W*N_REGIONS-1:0]   cfg_base,
  input  logic [Z3_AHI_W*N_REGIONS-1:0]   cfg_mask,
  input  logic [N_REGIONS-1:0]            cfg_valid,
  output logic                            req,
  output logic [region_w(N_REGIONS)-1:0]  req_region,
  output logic [3:0]                      req_ben,
  input  logic                            ack,
  output logic                            slave_n,
  output logic                            dtack_n,
  output logic                            dtack_oe,
  output logic                            mtack_n,
  output logic                            bufoe_n,
  output logic                            bufdir,
  output logic                            timeout
);

  localparam int RW    = region_w(N_REGIONS);
  localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0);

  logic [5:0] sync_in;
  logic [5:0] sync_out;
  logic       fcs_s;
  logic       mtcr_s;
  logic [3:0] ds_s;

  assign sync_in = {fcs_n, mtcr_n, ds_n};

  z3_sync #(.W(6)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sync_in),
    .q   (sync_out)
  );

  assign fcs_s  = sync_out[5];
  assign mtcr_s = sync_out[4];
  assign ds_s   = sync_out[3:0];

  z3_state_e        state_q, state_d;
  logic             fcs_prev_q, fcs_prev_d;
  logic [RW-1:0]    region_q, region_d;
  logic             req_q, req_d;
  logic [3:0]       ben_q, ben_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic          hit;
  logic [RW-1:0] hit_idx;
  logic          fcs_fall;
  logic          ds_any;
  logic          ds_idle;
  logic          expire;
  logic          active;

  // Scan from the top index down so the lowest matching region is the one kept.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (cfg_valid[i] &&
          (((addr_hi ^ cfg_base[i*Z3_AHI_W +: Z3_AHI_W]) & cfg_mask[i*Z3_AHI_W +: Z3_AHI_W]) == '0)) begin
        hit     = 1'b1;
        hit_idx = RW'(i);
      end
    end
  end

  assign fcs_fall = fcs_prev_q & ~fcs_s;
  assign ds_any   = ~&ds_s;
  assign ds_idle  = &ds_s;
  assign expire   = (TIMEOUT_CLKS != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fcs_prev_q <= 1'b1;
      region_q   <= '0;
      req_q      <= 1'b0;
      ben_q      <= '0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fcs_prev_q <= fcs_prev_d;
      region_q   <= region_d;
      req_q      <= req_d;
      ben_q      <= ben_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  // Bus error beats everything, including an ack in the same cycle; FCS release aborts next.
  always_comb begin
    state_d    = state_q;
    fcs_prev_d = fcs_s;
    region_d   = region_q;
    req_d      = 1'b0;
    ben_d      = ben_q;
    timeout_d  = 1'b0;
    cnt_d      = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fcs_fall) begin
          if (hit) begin
            state_d  = ST_DECODE;
            region_d = hit_idx;
          end else begin
            state_d = ST_MISS;
          end
        end
      end
      ST_DECODE: begin
        if (!berr_n)    state_d = ST_MISS;
        else if (fcs_s) state_d = ST_IDLE;
        else            state_d = ST_WAIT_DS;
      end
      ST_WAIT_DS: begin
        if (!berr_n)    state_d = ST_MISS;
        else if (fcs_s) state_d = ST_IDLE;
        else if (doe && ds_any) begin
          state_d = ST_WAIT_ACK;
          req_d   = 1'b1;
          ben_d   = ~ds_s;
          cnt_d   = '0;
        end
      end
      ST_WAIT_ACK: begin
        if (!berr_n)    state_d = ST_MISS;
        else if (fcs_s) state_d = ST_IDLE;
        else if (ack)   state_d = ST_HOLD;
        else if (expire) begin
          state_d   = ST_MISS;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!berr_n)    state_d = ST_MISS;
        else if (fcs_s) state_d = ST_IDLE;
        else if ((MULTI_XFER != 0) && ds_idle && mtcr_s) state_d = ST_BURST;
      end
      ST_BURST: begin
        if (!berr_n)    state_d = ST_MISS;
        else if (fcs_s) state_d = ST_IDLE;
        else if (!mtcr_s && ds_any) begin
          state_d = ST_WAIT_ACK;
          req_d   = 1'b1;
          ben_d   = ~ds_s;
          cnt_d   = '0;
        end
      end
      ST_MISS: begin
        if (fcs_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    active  = (state_q == ST_DECODE) || (state_q == ST_WAIT_DS) || (state_q == ST_WAIT_ACK) ||
              (state_q == ST_HOLD)   || (state_q == ST_BURST);
    slave_n = ~active;
    dtack_n = ~(state_q == ST_HOLD);
    mtack_n = ~(active && (MULTI_XFER != 0));
  end

  assign dtack_oe   = ~slave_n;
  assign bufoe_n    = slave_n | ~doe | ~berr_n;
  assign bufdir     = read;
  assign req        = req_q;
  assign req_ben    = ben_q;
  assign req_region = region_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_z3_slave_ctrl.sv
// Randomised self-checking bench for z3_slave_ctrl against a behavioural decode/transfer model.
module tb_z3_slave_ctrl;

  localparam int NR = 2;

  logic        clk;
  logic        rst;
  logic        fcs_n;
  logic [3:0]  ds_n;
  logic        mtcr_n;
  logic        read;
  logic        doe;
  logic        berr_n;
  logic [7:0]  addr_hi;
  logic [15:0] cfg_base;
  logic [15:0] cfg_mask;
  logic [1:0]  cfg_valid;
  logic        req;
  logic [0:0]  req_region;
  logic [3:0]  req_ben;
  logic        ack;
  logic        slave_n;
  logic        dtack_n;
  logic        dtack_oe;
  logic        mtack_n;
  logic        bufoe_n;
  logic        bufdir;
  logic        timeout;

  logic [7:0] baseArr [NR];
  logic [7:0] maskArr [NR];
  logic [1:0] validArr;

  int checkCount = 0;
  int passCount  = 0;
  int reqCount   = 0;

  z3_slave_ctrl #(.N_REGIONS(2), .MULTI_XFER(1), .TIMEOUT_CLKS(8)) dut (
    .clk(clk), .rst(rst), .fcs_n(fcs_n), .ds_n(ds_n), .mtcr_n(mtcr_n), .read(read),
    .doe(doe), .berr_n(berr_n), .addr_hi(addr_hi), .cfg_base(cfg_base), .cfg_mask(cfg_mask),
    .cfg_valid(cfg_valid), .req(req), .req_region(req_region), .req_ben(req_ben), .ack(ack),
    .slave_n(slave_n), .dtack_n(dtack_n), .dtack_oe(dtack_oe), .mtack_n(mtack_n),
    .bufoe_n(bufoe_n), .bufdir(bufdir), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (req === 1'b1) reqCount++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference decode: first enabled region whose masked base equals the masked address.
  function automatic void modelDecode(input logic [7:0] a, output bit h, output int idx);
    h = 0;
    idx = 0;
    for (int i = 0; i < NR; i++)
      if (!h && validArr[i] && ((a & maskArr[i]) == (baseArr[i] & maskArr[i]))) begin
        h = 1;
        idx = i;
      end
  endfunction

  task automatic setCfg();
    cfg_base  = {baseArr[1], baseArr[0]};
    cfg_mask  = {maskArr[1], maskArr[0]};
    cfg_valid = validArr;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".slave_n"}, slave_n, 1);
    checkOutput({tag, ".dtack_n"}, dtack_n, 1);
    checkOutput({tag, ".dtack_oe"}, dtack_oe, 0);
    checkOutput({tag, ".mtack_n"}, mtack_n, 1);
    checkOutput({tag, ".bufoe_n"}, bufoe_n, 1);
    checkOutput({tag, ".req"}, req, 0);
    checkOutput({tag, ".timeout"}, timeout, 0);
    checkOutput({tag, ".req_ben"}, req_ben, 0);
    checkOutput({tag, ".req_region"}, req_region, 0);
  endtask

  task automatic startCycle(input logic [7:0] a, input logic [3:0] ben, input logic mtcrLow);
    @(negedge clk);
    addr_hi = a;
    doe     = 1'b1;
    ds_n    = ~ben;
    mtcr_n  = ~mtcrLow;
    fcs_n   = 1'b0;
  endtask

  task automatic endCycle();
    @(negedge clk);
    fcs_n  = 1'b1;
    ds_n   = 4'hF;
    mtcr_n = 1'b1;
    doe    = 1'b0;
    ack    = 1'b0;
    berr_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic waitReq(input string tag);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req === 1'b1) break;
    end
    checkOutput(tag, req, 1);
  endtask

  // One full FCS cycle of 'beats' transfers, checked against the decode model.
  task automatic applyStimulus(input logic [7:0] a, input int beats, input logic rd, input bit changeCfg);
    bit h;
    int expReg;
    int startReq;
    int d;
    logic [3:0] ben;
    modelDecode(a, h, expReg);
    startReq = reqCount;
    ben = 4'($urandom_range(1, 15));
    read = rd;
    startCycle(a, ben, beats > 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("slaveEarly", slave_n, 1);
    @(negedge clk);
    checkOutput("slaveLatency", slave_n, h ? 0 : 1);
    if (!h) begin
      repeat (6) @(negedge clk);
      checkOutput("missSlave", slave_n, 1);
      checkOutput("missDtackOe", dtack_oe, 0);
      checkOutput("missReq", reqCount - startReq, 0);
      endCycle();
    end else begin
      checkOutput("mtack", mtack_n, 0);
      checkOutput("dtackOe", dtack_oe, 1);
      checkOutput("bufoe", bufoe_n, 0);
      checkOutput("bufdir", bufdir, rd);
      if (changeCfg) begin
        validArr = 2'b10;
        setCfg();
      end
      for (int b = 0; b < beats; b++) begin
        if (b > 0) begin
          ben = 4'($urandom_range(1, 15));
          ds_n = ~ben;
          mtcr_n = 1'b0;
        end
        waitReq("reqSeen");
        checkOutput("reqBen", req_ben, ben);
        checkOutput("reqRegion", req_region, expReg);
        d = $urandom_range(0, 5);
        repeat (d) @(negedge clk);
        checkOutput("dtackPreAck", dtack_n, 1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checkOutput("dtackAfterAck", dtack_n, 0);
        @(negedge clk);
        ds_n = 4'hF;
        mtcr_n = 1'b1;
        if (b == beats - 1) begin
          fcs_n = 1'b1;
        end else begin
          for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dtack_n === 1'b1) break;
          end
          checkOutput("burstDtackHigh", dtack_n, 1);
        end
      end
      repeat (4) @(negedge clk);
      checkOutput("endSlave", slave_n, 1);
      checkOutput("endDtackOe", dtack_oe, 0);
      checkOutput("reqPulses", reqCount - startReq, beats);
      doe = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic berrCycle(input logic [7:0] a);
    int startReq;
    startReq = reqCount;
    startCycle(a, 4'h3, 1'b0);
    waitReq("berrReq");
    ack = 1'b1;
    berr_n = 1'b0;
    @(negedge clk);
    ack = 1'b0;
    berr_n = 1'b1;
    checkOutput("berrDtack", dtack_n, 1);
    checkOutput("berrSlave", slave_n, 1);
    repeat (3) @(negedge clk);
    checkOutput("berrStaysMiss", slave_n, 1);
    checkOutput("berrDtackHold", dtack_n, 1);
    checkOutput("berrReqCount", reqCount - startReq, 1);
    endCycle();
  endtask

  task automatic timeoutCycle(input logic [7:0] a);
    bit early;
    startCycle(a, 4'hF, 1'b0);
    waitReq("toReq");
    early = 0;
    repeat (7) begin
      @(negedge clk);
      if (timeout === 1'b1) early = 1;
    end
    checkOutput("toEarly", early, 0);
    @(negedge clk);
    checkOutput("toPulse", timeout, 1);
    checkOutput("toSlave", slave_n, 1);
    @(negedge clk);
    checkOutput("toOnce", timeout, 0);
    endCycle();
  endtask

  task automatic abortCycle(input logic [7:0] a);
    bit sawDtack;
    startCycle(a, 4'h8, 1'b0);
    waitReq("abortReq");
    fcs_n = 1'b1;
    ds_n = 4'hF;
    sawDtack = 0;
    repeat (3) begin
      @(negedge clk);
      if (dtack_n === 1'b0) sawDtack = 1;
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (dtack_n === 1'b0) sawDtack = 1;
    end
    checkOutput("abortNoDtack", sawDtack, 0);
    checkOutput("abortSlave", slave_n, 1);
    endCycle();
  endtask

  task automatic resetMidBurst(input logic [7:0] a);
    startCycle(a, 4'hC, 1'b1);
    waitReq("rstReq");
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checkOutput("rstDtackLow", dtack_n, 0);
    rst = 1'b1;
    #1;
    checkResetOutputs("midRst");
    fcs_n = 1'b1;
    ds_n = 4'hF;
    mtcr_n = 1'b1;
    doe = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] a;
    int r;
    rst = 1'b1;
    fcs_n = 1'b1;
    ds_n = 4'hF;
    mtcr_n = 1'b1;
    read = 1'b0;
    doe = 1'b0;
    berr_n = 1'b1;
    ack = 1'b0;
    addr_hi = 8'h00;
    baseArr[0] = 8'h40; maskArr[0] = 8'hF0;
    baseArr[1] = 8'h20; maskArr[1] = 8'hF0;
    validArr = 2'b11;
    setCfg();
    #1;
    checkResetOutputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus(8'h4A, 1, 1'b1, 1'b0);
    applyStimulus(8'h80, 1, 1'b0, 1'b0);
    applyStimulus(8'h47, 4, 1'b1, 1'b0);

    baseArr[1] = 8'h40; maskArr[1] = 8'hC0;
    setCfg();
    applyStimulus(8'h45, 2, 1'b0, 1'b1);
    applyStimulus(8'h45, 1, 1'b1, 1'b0);

    berrCycle(8'h45);
    timeoutCycle(8'h45);
    abortCycle(8'h41);
    resetMidBurst(8'h45);
    applyStimulus(8'h45, 1, 1'b0, 1'b0);

    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < NR; i++) begin
        baseArr[i] = 8'($urandom);
        maskArr[i] = 8'($urandom);
      end
      validArr = 2'($urandom);
      setCfg();
      if ($urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, NR - 1);
        a = (baseArr[r] & maskArr[r]) | (8'($urandom) & ~maskArr[r]);
      end else begin
        a = 8'($urandom);
      end
      applyStimulus(a, $urandom_range(1, 4), 1'($urandom), 1'b0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
